// File: rtl/rs_pkg.sv
// rs_pkg: shared RS(255,239,T=8) GF(2^8) parameters, field polynomial and sequencer states.
package rs_pkg;
  localparam int M = 8;
  localparam int TMAX = 8;
  localparam int KMAX = 239;
  localparam int KW = 8;
  localparam int TW = 4;
  localparam logic [M:0] GF_POLY = 9'h11D;
  typedef enum logic [1:0] {IDLE, DATA, SETTLE, PARITY} state_e;
  function automatic logic cfg_legal(input logic [KW-1:0] k, input logic [TW-1:0] t);
    return k != '0 && k <= KW'(KMAX) && t <= TW'(TMAX);
  endfunction
endpackage

// File: rtl/rs_block_ctrl_if.sv
// rs_block_ctrl_if: config, upstream, encoder and downstream signals of the block sequencer.
interface rs_block_ctrl_if;
  import rs_pkg::*;
  logic cfg_valid;
  logic [KW-1:0] cfg_k;
  logic [TW-1:0] cfg_t;
  logic cfg_ready;
  logic err_cfg;
  logic [M-1:0] in_data;
  logic in_valid;
  logic in_ready;
  logic enc_clear;
  logic [M-1:0] enc_in;
  logic enc_in_valid;
  logic [M-1:0] enc_par;
  logic enc_par_shift;
  logic [M-1:0] out_data;
  logic out_valid;
  logic out_last;
  logic out_ready;
  logic busy;
  modport master (
    input cfg_valid, cfg_k, cfg_t, in_data, in_valid, enc_par, out_ready,
    output cfg_ready, err_cfg, in_ready, enc_clear, enc_in, enc_in_valid, enc_par_shift,
    output out_data, out_valid, out_last, busy
  );
  modport slave (
    output cfg_valid, cfg_k, cfg_t, in_data, in_valid, enc_par, out_ready,
    input cfg_ready, err_cfg, in_ready, enc_clear, enc_in, enc_in_valid, enc_par_shift,
    input out_data, out_valid, out_last, busy
  );
endinterface

// File: rtl/rs_block_ctrl.sv
// rs_block_ctrl: per-block sequencer feeding K data bytes to the RS encoder, then draining 2T parity bytes.
module rs_block_ctrl
  import rs_pkg::*;
(
  input logic clk,
  input logic reset,
  rs_block_ctrl_if.master bus
);
  state_e state_q, state_d;
  logic [KW-1:0] k_q, k_d, dcnt_q, dcnt_d;
  logic [TW-1:0] t_q, t_d;
  logic [TW:0] pcnt_q, pcnt_d, npar;
  logic [M-1:0] out_data_q, out_data_d, enc_in_q, enc_in_d;
  logic out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic enc_in_valid_q, enc_in_valid_d, enc_clear_q, enc_clear_d, err_q, err_d;
  logic slot_free, in_rdy, par_shift, last_data;
  assign slot_free = !out_valid_q || bus.out_ready;
  assign npar = {t_q, 1'b0};
  assign last_data = dcnt_q == k_q - KW'(1);
  assign in_rdy = !reset && state_q == DATA && slot_free;
  // parity head is sampled and the encoder advanced on the same edge
  assign par_shift = !reset && state_q == PARITY && slot_free && pcnt_q != npar;
  always_comb begin
    state_d = state_q;
    k_d = k_q;
    t_d = t_q;
    dcnt_d = dcnt_q;
    pcnt_d = pcnt_q;
    enc_in_d = enc_in_q;
    enc_in_valid_d = 1'b0;
    enc_clear_d = 1'b0;
    err_d = 1'b0;
    out_data_d = out_data_q;
    out_valid_d = out_valid_q && !bus.out_ready;
    out_last_d = out_last_q && !bus.out_ready;
    unique case (state_q)
      IDLE: if (bus.cfg_valid) begin
        if (cfg_legal(bus.cfg_k, bus.cfg_t)) begin
          state_d = DATA;
          k_d = bus.cfg_k;
          t_d = bus.cfg_t;
          dcnt_d = '0;
          pcnt_d = '0;
          enc_clear_d = 1'b1;
        end else err_d = 1'b1;
      end
      DATA: if (in_rdy && bus.in_valid) begin
        out_data_d = bus.in_data;
        enc_in_d = bus.in_data;
        out_valid_d = 1'b1;
        enc_in_valid_d = 1'b1;
        dcnt_d = dcnt_q + 1'b1;
        out_last_d = last_data && t_q == '0;
        if (last_data) state_d = t_q == '0 ? IDLE : SETTLE;
      end
      SETTLE: state_d = PARITY;
      PARITY: if (pcnt_q == npar) state_d = IDLE;
        else if (par_shift) begin
          out_data_d = bus.enc_par;
          out_valid_d = 1'b1;
          out_last_d = pcnt_q == npar - 1'b1;
          pcnt_d = pcnt_q + 1'b1;
        end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      k_q <= '0;
      t_q <= '0;
      dcnt_q <= '0;
      pcnt_q <= '0;
      enc_in_q <= '0;
      enc_in_valid_q <= 1'b0;
      enc_clear_q <= 1'b1;
      err_q <= 1'b0;
      out_data_q <= '0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q <= k_d;
      t_q <= t_d;
      dcnt_q <= dcnt_d;
      pcnt_q <= pcnt_d;
      enc_in_q <= enc_in_d;
      enc_in_valid_q <= enc_in_valid_d;
      enc_clear_q <= enc_clear_d;
      err_q <= err_d;
      out_data_q <= out_data_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
    end
  end
  assign bus.cfg_ready = !reset && state_q == IDLE;
  assign bus.err_cfg = err_q;
  assign bus.in_ready = in_rdy;
  assign bus.enc_clear = enc_clear_q;
  assign bus.enc_in = enc_in_q;
  assign bus.enc_in_valid = enc_in_valid_q;
  assign bus.enc_par_shift = par_shift;
  assign bus.out_data = out_data_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_last = out_last_q;
  assign bus.busy = state_q != IDLE;
endmodule
